// File: rtl/ct_ifu_btb_upd_buf_if.sv
// Bundles the addrgen update strobe, cp0 controls and the BTB SRAM write port
// seen by the BTB update buffer; the buffer uses the slave modport.
interface ct_ifu_btb_upd_buf_if #(
   parameter int INDEX_W = 10,
   parameter int TAG_W   = 10,
   parameter int TGT_W   = 20
);
   logic               cp0_ifu_btb_en;
   logic               cp0_ifu_btb_inv;
   logic               addrgen_btb_update_vld;
   logic [INDEX_W-1:0] addrgen_btb_index;
   logic [TAG_W-1:0]   addrgen_btb_tag;
   logic [TGT_W-1:0]   addrgen_btb_target_pc;
   logic               btb_updbuf_gnt;
   logic               updbuf_btb_req;
   logic [INDEX_W-1:0] updbuf_btb_index;
   logic [TAG_W-1:0]   updbuf_btb_tag;
   logic [TGT_W-1:0]   updbuf_btb_target_pc;
   logic               updbuf_empty;
   logic               updbuf_full;
   logic               ifu_hpcp_btb_upd_drop;
   logic               ifu_hpcp_btb_upd_merge;

   modport master (
      output cp0_ifu_btb_en, cp0_ifu_btb_inv, addrgen_btb_update_vld,
             addrgen_btb_index, addrgen_btb_tag, addrgen_btb_target_pc, btb_updbuf_gnt,
      input  updbuf_btb_req, updbuf_btb_index, updbuf_btb_tag, updbuf_btb_target_pc,
             updbuf_empty, updbuf_full, ifu_hpcp_btb_upd_drop, ifu_hpcp_btb_upd_merge
   );

   modport slave (
      input  cp0_ifu_btb_en, cp0_ifu_btb_inv, addrgen_btb_update_vld,
             addrgen_btb_index, addrgen_btb_tag, addrgen_btb_target_pc, btb_updbuf_gnt,
      output updbuf_btb_req, updbuf_btb_index, updbuf_btb_tag, updbuf_btb_target_pc,
             updbuf_empty, updbuf_full, ifu_hpcp_btb_upd_drop, ifu_hpcp_btb_upd_merge
   );
endinterface

// File: rtl/ct_ifu_btb_upd_buf.sv
// Coalescing FIFO between addrgen BTB mispredict updates and the BTB SRAM write
// port. All outputs are flops loaded from the next-state of the buffer.
module ct_ifu_btb_upd_buf #(
   parameter int DEPTH   = 4,
   parameter int PTR_W   = 2,
   parameter int INDEX_W = 10,
   parameter int TAG_W   = 10,
   parameter int TGT_W   = 20
) (
   input logic                 forever_cpuclk,
   input logic                 cpurst_b,
   ct_ifu_btb_upd_buf_if.slave upd_if
);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DEPTH-1:0]   valid_r;
   logic [DEPTH-1:0]   valid_nxt_s;
   logic [DEPTH-1:0]   match_vec_s;
   logic [INDEX_W-1:0] idx_r       [DEPTH];
   logic [INDEX_W-1:0] idx_nxt_s   [DEPTH];
   logic [TAG_W-1:0]   tag_r       [DEPTH];
   logic [TAG_W-1:0]   tag_nxt_s   [DEPTH];
   logic [TGT_W-1:0]   tgt_r       [DEPTH];
   logic [TGT_W-1:0]   tgt_nxt_s   [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_nxt_s;
   logic [PTR_W-1:0]   wr_ptr_nxt_s;
   logic [PTR_W-1:0]   match_sel_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   cnt_nxt_s;
   logic               flush_s;
   logic               strobe_s;
   logic               pop_s;
   logic               match_any_s;
   logic               merge_s;
   logic               push_s;
   logic               drop_s;
   logic               req_r;
   logic               empty_r;
   logic               full_r;
   logic               drop_r;
   logic               merge_r;
   logic [INDEX_W-1:0] head_idx_r;
   logic [TAG_W-1:0]   head_tag_r;
   logic [TGT_W-1:0]   head_tgt_r;

   // A flush swallows any same-cycle strobe; a same-cycle grant leaves state alone.
   assign flush_s     = upd_if.cp0_ifu_btb_inv | ~upd_if.cp0_ifu_btb_en;
   assign strobe_s    = upd_if.addrgen_btb_update_vld & ~flush_s;
   assign pop_s       = valid_r[rd_ptr_r] & upd_if.btb_updbuf_gnt;
   assign match_any_s = |match_vec_s;
   assign merge_s     = strobe_s & match_any_s;
   assign push_s      = strobe_s & ~match_any_s & ((cnt_r != FULL_CNT) | pop_s);
   assign drop_s      = strobe_s & ~match_any_s & (cnt_r == FULL_CNT) & ~pop_s;

   // Find the live entry with the same {index,tag}; a head retiring this cycle is excluded.
   always_comb begin
      match_vec_s = '0;
      match_sel_s = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_vec_s[i] = valid_r[i]
                        & (idx_r[i] == upd_if.addrgen_btb_index)
                        & (tag_r[i] == upd_if.addrgen_btb_tag)
                        & ~(pop_s & (rd_ptr_r == PTR_W'(i)));
         match_sel_s    = match_sel_s | ({PTR_W{match_vec_s[i]}} & PTR_W'(i));
      end
   end

   // Next-state of valids, payloads, pointers and occupancy.
   always_comb begin
      valid_nxt_s  = valid_r;
      idx_nxt_s    = idx_r;
      tag_nxt_s    = tag_r;
      tgt_nxt_s    = tgt_r;
      rd_ptr_nxt_s = rd_ptr_r;
      wr_ptr_nxt_s = wr_ptr_r;
      cnt_nxt_s    = cnt_r;
      if (flush_s) begin
         valid_nxt_s  = '0;
         rd_ptr_nxt_s = '0;
         wr_ptr_nxt_s = '0;
         cnt_nxt_s    = '0;
      end else begin
         if (pop_s) begin
            valid_nxt_s[rd_ptr_r] = 1'b0;
            rd_ptr_nxt_s          = rd_ptr_r + PTR_W'(1);
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
         // When full, push and pop hit the same slot; the push must win.
         if (merge_s) begin
            tgt_nxt_s[match_sel_s] = upd_if.addrgen_btb_target_pc;
         end else if (push_s) begin
            valid_nxt_s[wr_ptr_r] = 1'b1;
            idx_nxt_s[wr_ptr_r]   = upd_if.addrgen_btb_index;
            tag_nxt_s[wr_ptr_r]   = upd_if.addrgen_btb_tag;
            tgt_nxt_s[wr_ptr_r]   = upd_if.addrgen_btb_target_pc;
            wr_ptr_nxt_s          = wr_ptr_r + PTR_W'(1);
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
            default: cnt_nxt_s = cnt_r;
         endcase
      end
   end

   // Buffer state and registered outputs.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         valid_r    <= '0;
         rd_ptr_r   <= '0;
         wr_ptr_r   <= '0;
         cnt_r      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            idx_r[i] <= '0;
            tag_r[i] <= '0;
            tgt_r[i] <= '0;
         end
         req_r      <= 1'b0;
         empty_r    <= 1'b1;
         full_r     <= 1'b0;
         drop_r     <= 1'b0;
         merge_r    <= 1'b0;
         head_idx_r <= '0;
         head_tag_r <= '0;
         head_tgt_r <= '0;
      end else begin
         valid_r    <= valid_nxt_s;
         rd_ptr_r   <= rd_ptr_nxt_s;
         wr_ptr_r   <= wr_ptr_nxt_s;
         cnt_r      <= cnt_nxt_s;
         idx_r      <= idx_nxt_s;
         tag_r      <= tag_nxt_s;
         tgt_r      <= tgt_nxt_s;
         req_r      <= valid_nxt_s[rd_ptr_nxt_s];
         empty_r    <= (cnt_nxt_s == '0);
         full_r     <= (cnt_nxt_s == FULL_CNT);
         drop_r     <= drop_s;
         merge_r    <= merge_s;
         head_idx_r <= idx_nxt_s[rd_ptr_nxt_s];
         head_tag_r <= tag_nxt_s[rd_ptr_nxt_s];
         head_tgt_r <= tgt_nxt_s[rd_ptr_nxt_s];
      end
   end

   assign upd_if.updbuf_btb_req         = req_r;
   assign upd_if.updbuf_btb_index       = head_idx_r;
   assign upd_if.updbuf_btb_tag         = head_tag_r;
   assign upd_if.updbuf_btb_target_pc   = head_tgt_r;
   assign upd_if.updbuf_empty           = empty_r;
   assign upd_if.updbuf_full            = full_r;
   assign upd_if.ifu_hpcp_btb_upd_drop  = drop_r;
   assign upd_if.ifu_hpcp_btb_upd_merge = merge_r;
endmodule

// File: tb/tb_ct_ifu_btb_upd_buf.sv
// Directed vector bench for the BTB update buffer: table rows plus hand-written
// flush and asynchronous-reset sequences.
module tb_ct_ifu_btb_upd_buf;
   localparam int DEPTH   = 4;
   localparam int PTR_W   = 2;
   localparam int INDEX_W = 10;
   localparam int TAG_W   = 10;
   localparam int TGT_W   = 20;

   typedef struct {
      int en, inv, vld, idx, tag, tgt, gnt;
      int req, eidx, etag, etgt, empty, full, drop, merge;
   } vec_t;

   logic   clk = 1'b0;
   logic   rst_b = 1'b0;
   int     pass_cnt = 0;
   int     tot_cnt = 0;
   vec_t   vecs[$];

   ct_ifu_btb_upd_buf_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .TGT_W(TGT_W)) u_if ();

   ct_ifu_btb_upd_buf #(
      .DEPTH(DEPTH), .PTR_W(PTR_W), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .TGT_W(TGT_W)
   ) u_dut (
      .forever_cpuclk(clk),
      .cpurst_b      (rst_b),
      .upd_if        (u_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int row, input int act, input int exp);
      tot_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s (row %0d): got %0h expected %0h", nm, row, act, exp);
   endtask

   task automatic add(input int en, input int inv, input int vld, input int idx, input int tag,
                      input int tgt, input int gnt, input int req, input int eidx, input int etag,
                      input int etgt, input int empty, input int full, input int drop,
                      input int merge);
      vec_t v;
      v = '{en, inv, vld, idx, tag, tgt, gnt, req, eidx, etag, etgt, empty, full, drop, merge};
      vecs.push_back(v);
   endtask

   task automatic drive(input int en, input int inv, input int vld, input int idx, input int tag,
                        input int tgt, input int gnt);
      @(negedge clk);
      u_if.cp0_ifu_btb_en         = 1'(en);
      u_if.cp0_ifu_btb_inv        = 1'(inv);
      u_if.addrgen_btb_update_vld = 1'(vld);
      u_if.addrgen_btb_index      = INDEX_W'(idx);
      u_if.addrgen_btb_tag        = TAG_W'(tag);
      u_if.addrgen_btb_target_pc  = TGT_W'(tgt);
      u_if.btb_updbuf_gnt         = 1'(gnt);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_flags(input string nm, input int row, input int req, input int empty,
                            input int full, input int drop, input int merge);
      chk({nm, ".req"},   row, int'(u_if.updbuf_btb_req), req);
      chk({nm, ".empty"}, row, int'(u_if.updbuf_empty), empty);
      chk({nm, ".full"},  row, int'(u_if.updbuf_full), full);
      chk({nm, ".drop"},  row, int'(u_if.ifu_hpcp_btb_upd_drop), drop);
      chk({nm, ".merge"}, row, int'(u_if.ifu_hpcp_btb_upd_merge), merge);
   endtask

   task automatic chk_head(input string nm, input int row, input int idx, input int tag,
                           input int tgt);
      chk({nm, ".idx"}, row, int'(u_if.updbuf_btb_index), idx);
      chk({nm, ".tag"}, row, int'(u_if.updbuf_btb_tag), tag);
      chk({nm, ".tgt"}, row, int'(u_if.updbuf_btb_target_pc), tgt);
   endtask

   initial begin
      u_if.cp0_ifu_btb_en         = 1'b1;
      u_if.cp0_ifu_btb_inv        = 1'b0;
      u_if.addrgen_btb_update_vld = 1'b0;
      u_if.addrgen_btb_index      = '0;
      u_if.addrgen_btb_tag        = '0;
      u_if.addrgen_btb_target_pc  = '0;
      u_if.btb_updbuf_gnt         = 1'b0;

      // single update, granted on first request
      add(1, 0, 1, 'h005, 'h012, 'hABCDE, 1,  1, 'h005, 'h012, 'hABCDE, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1,                0, 0, 0, 0,               1, 0, 0, 0);
      // fill, drop on full, drain in order
      for (int k = 1; k <= 4; k++)
         add(1, 0, 1, k, 0, 'h11 * k, 0,      1, 1, 0, 'h11,            0, int'(k == 4), 0, 0);
      add(1, 0, 1, 5, 0, 'h55, 0,             1, 1, 0, 'h11,            0, 1, 1, 0);
      for (int k = 2; k <= 4; k++)
         add(1, 0, 0, 0, 0, 0, 1,             1, k, 0, 'h11 * k,        0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1,                0, 0, 0, 0,               1, 0, 0, 0);
      // coalescing of a repeated {index,tag}
      add(1, 0, 1, 7, 3, 'h100, 0,            1, 7, 3, 'h100,           0, 0, 0, 0);
      add(1, 0, 1, 7, 3, 'h200, 0,            1, 7, 3, 'h200,           0, 0, 0, 1);
      add(1, 0, 0, 0, 0, 0, 0,                1, 7, 3, 'h200,           0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1,                0, 0, 0, 0,               1, 0, 0, 0);
      // push and pop while full, pointers wrap three times
      for (int k = 0; k < 4; k++)
         add(1, 0, 1, 'h10 + k, 1, 'h1010 + k, 0, 1, 'h10, 1, 'h1010,   0, int'(k == 3), 0, 0);
      for (int k = 0; k < 12; k++)
         add(1, 0, 1, 'h14 + k, 1, 'h1014 + k, 1, 1, 'h11 + k, 1, 'h1011 + k, 0, 1, 0, 0);
      for (int k = 0; k < 3; k++)
         add(1, 0, 0, 0, 0, 0, 1,             1, 'h1D + k, 1, 'h101D + k, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1,                0, 0, 0, 0,               1, 0, 0, 0);
      // same key as the head being popped becomes a new entry
      add(1, 0, 1, 9, 1, 'h44, 0,             1, 9, 1, 'h44,            0, 0, 0, 0);
      add(1, 0, 1, 9, 1, 'h55, 1,             1, 9, 1, 'h55,            0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1,                0, 0, 0, 0,               1, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      chk_flags("reset", -1, 0, 1, 0, 0, 0);
      chk_head("reset", -1, 0, 0, 0);
      @(negedge clk);
      rst_b = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].en, vecs[i].inv, vecs[i].vld, vecs[i].idx, vecs[i].tag, vecs[i].tgt,
               vecs[i].gnt);
         chk_flags("vec", i, vecs[i].req, vecs[i].empty, vecs[i].full, vecs[i].drop,
                   vecs[i].merge);
         if (vecs[i].req != 0) chk_head("vec", i, vecs[i].eidx, vecs[i].etag, vecs[i].etgt);
      end

      // invalidate with a mergeable strobe and a grant in the same cycle
      for (int k = 0; k < 3; k++) drive(1, 0, 1, 'h21 + k, 2, 'h300 + k, 0);
      chk_flags("inv_pre", 0, 1, 0, 0, 0, 0);
      chk_head("inv_pre", 0, 'h21, 2, 'h300);
      drive(1, 1, 1, 'h22, 2, 'h999, 1);
      chk_flags("inv", 0, 0, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 1, 'h50 + k, 2, 'h400 + k, 1);
         chk_flags("btb_dis", k, 0, 1, 0, 0, 0);
      end
      drive(1, 0, 1, 'h60, 4, 'h600, 0);
      chk_flags("re_en", 0, 1, 0, 0, 0, 0);
      chk_head("re_en", 0, 'h60, 4, 'h600);
      drive(1, 0, 0, 0, 0, 0, 1);
      chk_flags("re_en", 1, 0, 1, 0, 0, 0);

      // asynchronous reset between clock edges while draining
      for (int k = 0; k < 4; k++) drive(1, 0, 1, 'h31 + k, 5, 'h700 + k, 0);
      chk_flags("rst_pre", 0, 1, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 1);
      chk_flags("rst_pre", 1, 1, 0, 0, 0, 0);
      chk_head("rst_pre", 1, 'h32, 5, 'h701);
      #2;
      rst_b = 1'b0;
      #1;
      chk_flags("async_rst", 0, 0, 1, 0, 0, 0);
      chk_head("async_rst", 0, 0, 0, 0);
      @(negedge clk);
      rst_b = 1'b1;
      drive(1, 0, 1, 'h70, 6, 'h800, 0);
      chk_flags("post_rst", 0, 1, 0, 0, 0, 0);
      chk_head("post_rst", 0, 'h70, 6, 'h800);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
